elevator_request_latch: RTL and testbench

Upstream input stage for the elevator controller. It conditions the four cabin buttons (KEY, active-low) and the four hall-call switches (SW, active-high) and keeps a per-floor pending-request bitmap. The elevator FSM reads the bitmap and clears each floor when it opens the door there. Conditioning is a two-flop synchronizer plus a per-input debounce state machine, so one physical press gives exactly one registered request.

---
 rtl/elevator_request_latch.sv | 224 ++++++++++++++++++++++
 tb/tb_elevator_request_latch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_request_latch.sv
// elevator_request_latch
//   Input conditioning and request latching for the elevator controller.
//   Each cabin button (KEY, active-low) and hall-call switch (SW, active-high)
//   is synchronised with two flops, normalised to a "pressed" level and
//   debounced by its own four-state machine. A debounced press sets the
//   floor's request bit and strobes req_pulse; the FSM clears floors it has
//   serviced via clr_valid/clr_floor.
//
// Ports
//   CLOCK_50   in   system clock
//   reset      in   synchronous active-high reset
//   KEY        in   [FLOORS] cabin buttons, active-low, asynchronous
//   SW         in   [FLOORS] hall-call switches, active-high, asynchronous
//   clr_valid  in   clear strobe from the elevator FSM
//   clr_floor  in   [2] floor index to clear, 0-based
//   pending    out  [FLOORS] cabin_req | hall_req
//   cabin_req  out  [FLOORS] latched cabin requests
//   hall_req   out  [FLOORS] latched hall calls
//   req_pulse  out  [FLOORS] one-cycle strobe per accepted press
module elevator_request_latch #(
  parameter int unsigned FLOORS   = 4,
  parameter int unsigned DEBOUNCE = 1000000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [FLOORS-1:0] KEY,
  input  logic [FLOORS-1:0] SW,
  input  logic              clr_valid,
  input  logic [1:0]        clr_floor,
  output logic [FLOORS-1:0] pending,
  output logic [FLOORS-1:0] cabin_req,
  output logic [FLOORS-1:0] hall_req,
  output logic [FLOORS-1:0] req_pulse
);

  // Debouncers 0..FLOORS-1 are cabin buttons, FLOORS..2*FLOORS-1 hall calls.
  localparam int unsigned NIN = 2 * FLOORS;
  localparam int unsigned CLR_W = 2;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
  // The edge that would bring the count to DEBOUNCE is the accepting edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_REL   = 2'd0,
    ST_CHK_P = 2'd1,
    ST_PRS   = 2'd2,
    ST_CHK_R = 2'd3
  } db_state_e;

  // Saturating increment; never wraps past DEBOUNCE.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v < CNT_MAX) ? (v + CNT_ONE) : v;
  endfunction

  // ------------------------------------------------------------------------
  // Two-flop synchronizers; reset to the released level of each input.
  // ------------------------------------------------------------------------
  logic [FLOORS-1:0] key_s1_q, key_s1_d;
  logic [FLOORS-1:0] key_s2_q, key_s2_d;
  logic [FLOORS-1:0] sw_s1_q,  sw_s1_d;
  logic [FLOORS-1:0] sw_s2_q,  sw_s2_d;

  always_comb begin
    key_s1_d = KEY;
    key_s2_d = key_s1_q;
    sw_s1_d  = SW;
    sw_s2_d  = sw_s1_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_s1_q <= '1;
      key_s2_q <= '1;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
    end
  end

  // Normalised pressed level: cabin buttons inverted, hall calls as-is.
  logic [NIN-1:0] pressed_c;
  assign pressed_c = {sw_s2_q, ~key_s2_q};

  // ------------------------------------------------------------------------
  // Per-input debounce FSMs: state register.
  // ------------------------------------------------------------------------
  db_state_e        state_q [NIN];
  db_state_e        state_d [NIN];
  logic [CNT_W-1:0] cnt_q   [NIN];
  logic [CNT_W-1:0] cnt_d   [NIN];
  logic [NIN-1:0]   accept_c;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int j = 0; j < NIN; j++) begin
        state_q[j] <= ST_REL;
        cnt_q[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < NIN; j++) begin
        state_q[j] <= state_d[j];
        cnt_q[j]   <= cnt_d[j];
      end
    end
  end

  // Per-input debounce FSMs: next state, counter and accept strobe.
  always_comb begin
    for (int j = 0; j < NIN; j++) begin
      state_d[j]  = state_q[j];
      cnt_d[j]    = cnt_q[j];
      accept_c[j] = 1'b0;

      case (state_q[j])
        ST_REL: begin
          if (pressed_c[j]) begin
            state_d[j] = ST_CHK_P;
            cnt_d[j]   = CNT_ONE;
          end
        end

        ST_CHK_P: begin
          if (!pressed_c[j]) begin
            state_d[j] = ST_REL;
            cnt_d[j]   = '0;
          end else if (cnt_q[j] >= CNT_LAST) begin
            // The only path that produces a request.
            state_d[j]  = ST_PRS;
            cnt_d[j]    = CNT_MAX;
            accept_c[j] = 1'b1;
          end else begin
            cnt_d[j] = sat_inc(cnt_q[j]);
          end
        end

        ST_PRS: begin
          if (!pressed_c[j]) begin
            state_d[j] = ST_CHK_R;
            cnt_d[j]   = CNT_ONE;
          end
        end

        ST_CHK_R: begin
          if (pressed_c[j]) begin
            state_d[j] = ST_PRS;
            cnt_d[j]   = CNT_MAX;
          end else if (cnt_q[j] >= CNT_LAST) begin
            state_d[j] = ST_REL;
            cnt_d[j]   = '0;
          end else begin
            cnt_d[j] = sat_inc(cnt_q[j]);
          end
        end

        default: begin
          state_d[j] = ST_REL;
          cnt_d[j]   = '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Request latches, clear decode and pulse generation.
  // ------------------------------------------------------------------------
  logic [FLOORS-1:0] accept_cabin_c;
  logic [FLOORS-1:0] accept_hall_c;
  logic [FLOORS-1:0] clr_mask_c;

  logic [FLOORS-1:0] cabin_req_q, cabin_req_d;
  logic [FLOORS-1:0] hall_req_q,  hall_req_d;
  logic [FLOORS-1:0] pending_q,   pending_d;
  logic [FLOORS-1:0] req_pulse_q, req_pulse_d;

  assign accept_cabin_c = accept_c[FLOORS-1:0];
  assign accept_hall_c  = accept_c[NIN-1:FLOORS];

  // One-hot clear; an index beyond the last floor matches no bit.
  always_comb begin
    clr_mask_c = '0;
    for (int i = 0; i < FLOORS; i++) begin
      clr_mask_c[i] = clr_valid && (32'(clr_floor) == 32'(i));
    end
  end

  // Clear has priority over a same-cycle accept; the pulse still fires.
  always_comb begin
    cabin_req_d = (cabin_req_q | accept_cabin_c) & ~clr_mask_c;
    hall_req_d  = (hall_req_q  | accept_hall_c)  & ~clr_mask_c;
    pending_d   = cabin_req_d | hall_req_d;
    req_pulse_d = accept_cabin_c | accept_hall_c;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cabin_req_q <= '0;
      hall_req_q  <= '0;
      pending_q   <= '0;
      req_pulse_q <= '0;
    end else begin
      cabin_req_q <= cabin_req_d;
      hall_req_q  <= hall_req_d;
      pending_q   <= pending_d;
      req_pulse_q <= req_pulse_d;
    end
  end

  assign cabin_req = cabin_req_q;
  assign hall_req  = hall_req_q;
  assign pending   = pending_q;
  assign req_pulse = req_pulse_q;

  // Index width is fixed by the interface; keep the localparam referenced.
  logic [CLR_W-1:0] clr_floor_unused_c;
  assign clr_floor_unused_c = clr_floor;

endmodule

// File: tb/tb_elevator_request_latch.sv
// Bench for elevator_request_latch with DEBOUNCE=4. Expected pulses are
// queued with their due edge when a press is driven and matched by a negedge
// monitor; latched state is checked against a vector table and a few
// hand-written multi-cycle sequences.
module tb_elevator_request_latch;

  localparam int unsigned FLOORS   = 4;
  localparam int unsigned DEBOUNCE = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int          SETTLE   = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic [FLOORS-1:0] KEY;
  logic [FLOORS-1:0] SW;
  logic              clr_valid;
  logic [1:0]        clr_floor;
  logic [FLOORS-1:0] pending;
  logic [FLOORS-1:0] cabin_req;
  logic [FLOORS-1:0] hall_req;
  logic [FLOORS-1:0] req_pulse;

  elevator_request_latch #(
    .FLOORS  (FLOORS),
    .DEBOUNCE(DEBOUNCE),
    .CNT_W   (CNT_W)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .KEY      (KEY),
    .SW       (SW),
    .clr_valid(clr_valid),
    .clr_floor(clr_floor),
    .pending  (pending),
    .cabin_req(cabin_req),
    .hall_req (hall_req),
    .req_pulse(req_pulse)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge n it reads n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] val;
    int         due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string      name;
    logic [3:0] key;
    logic [3:0] sw;
    int         hold;
    logic [3:0] pulse;
    logic [3:0] cabin;
    logic [3:0] hall;
    logic [3:0] pend;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A press driven now (just after edge cyc) is accepted at edge cyc+2+DEBOUNCE.
  task automatic expect_pulse(input logic [3:0] val);
    exp_t e;
    e.val = val;
    e.due = cyc + 2 + DEBOUNCE;
    sb.push_back(e);
  endtask

  task automatic clear_floor(input int f);
    clr_valid = 1'b1;
    clr_floor = 2'(f);
    tick(1);
    clr_valid = 1'b0;
  endtask

  task automatic clear_all();
    for (int f = 0; f < FLOORS; f++) clear_floor(f);
    chk("clear_all_pending", 32'(pending), 32'h0);
  endtask

  // Pulse scoreboard: every strobe must match the head entry and its due edge.
  always @(negedge clk) begin
    if (sb.size() > 0 && cyc > sb[0].due) begin
      checks++;
      errors++;
      $display("FAIL pulse_missing: got none expected %b at edge %0d", sb[0].val, sb[0].due);
      void'(sb.pop_front());
    end
    if (req_pulse !== 4'b0000) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pulse_unexpected: got %b expected none at edge %0d", req_pulse, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (e.val !== req_pulse || e.due != cyc) begin
          errors++;
          $display("FAIL pulse_match: got %b at edge %0d expected %b at edge %0d",
                   req_pulse, cyc, e.val, e.due);
        end
      end
    end
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"sw2_hold10",     4'b1111, 4'b0100, 10, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
    vecs[1] = '{"key0_glitch3",   4'b1110, 4'b0000,  3, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[2] = '{"key0_hold6",     4'b1110, 4'b0000,  6, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    vecs[3] = '{"sw3_sw1_pair",   4'b1111, 4'b1010,  8, 4'b1010, 4'b0000, 4'b1010, 4'b1010};
    vecs[4] = '{"mix_hold_exact", 4'b0110, 4'b0010,  4, 4'b1011, 4'b1001, 4'b0010, 4'b1011};
    vecs[5] = '{"all_keys_held",  4'b0000, 4'b0000, 20, 4'b1111, 4'b1111, 4'b0000, 4'b1111};
    vecs[6] = '{"sw0_glitch1",    4'b1111, 4'b0001,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    KEY       = 4'b1111;
    SW        = 4'b0000;
    clr_valid = 1'b0;
    clr_floor = 2'd0;
    reset     = 1'b1;

    // Reset then idle.
    tick(2);
    chk("reset_outputs", 32'({pending, cabin_req, hall_req, req_pulse}), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("idle_outputs", 32'({pending, cabin_req, hall_req, req_pulse}), 32'h0);
    end

    // Table-driven single presses from an idle, cleared state.
    for (int v = 0; v < 7; v++) begin
      KEY = vecs[v].key;
      SW  = vecs[v].sw;
      if (vecs[v].pulse != 4'b0000) expect_pulse(vecs[v].pulse);
      tick(vecs[v].hold);
      KEY = 4'b1111;
      SW  = 4'b0000;
      tick(SETTLE);
      chk({vecs[v].name, "_cabin"},   32'(cabin_req), 32'(vecs[v].cabin));
      chk({vecs[v].name, "_hall"},    32'(hall_req),  32'(vecs[v].hall));
      chk({vecs[v].name, "_pending"}, 32'(pending),   32'(vecs[v].pend));
      clear_all();
    end

    // Staged clears, ignored clr_floor without clr_valid, re-accept of a set bit.
    SW = 4'b1010;
    expect_pulse(4'b1010);
    tick(8);
    SW = 4'b0000;
    tick(SETTLE);
    chk("pair_pending", 32'(pending), 32'hA);
    clr_floor = 2'd1;
    tick(2);
    chk("no_clear_without_valid", 32'(pending), 32'hA);
    clear_floor(3);
    chk("clear3_pending", 32'(pending), 32'h2);
    SW = 4'b0010;
    expect_pulse(4'b0010);
    tick(6);
    SW = 4'b0000;
    tick(SETTLE);
    chk("reaccept_hall", 32'(hall_req), 32'h2);
    chk("reaccept_pending", 32'(pending), 32'h2);
    clear_floor(1);
    chk("clear1_pending", 32'(pending), 32'h0);

    // Accept on floors 2 and 0 in the same edge as a clear of floor 2.
    KEY = 4'b1010;
    expect_pulse(4'b0101);
    tick(1 + DEBOUNCE);
    clr_valid = 1'b1;
    clr_floor = 2'd2;
    tick(1);
    clr_valid = 1'b0;
    chk("same_cycle_cabin", 32'(cabin_req), 32'h1);
    chk("same_cycle_pending", 32'(pending), 32'h1);
    tick(3);
    KEY = 4'b1111;
    tick(SETTLE);
    chk("same_cycle_cabin_later", 32'(cabin_req), 32'h1);
    clear_all();

    // Reset in the middle of a latched request and of a CHK_P on SW[1].
    KEY = 4'b0111;
    expect_pulse(4'b1000);
    tick(6);
    KEY = 4'b1111;
    tick(SETTLE);
    chk("pre_reset_cabin", 32'(cabin_req), 32'h8);
    SW = 4'b0010;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("reset_mid_outputs", 32'({pending, cabin_req, hall_req, req_pulse}), 32'h0);
    tick(1);
    reset = 1'b0;
    expect_pulse(4'b0010);
    tick(10);
    SW = 4'b0000;
    tick(SETTLE);
    chk("post_reset_hall", 32'(hall_req), 32'h2);
    chk("post_reset_cabin", 32'(cabin_req), 32'h0);
    chk("post_reset_pending", 32'(pending), 32'h2);
    clear_all();

    tick(20);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
